multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 (single clock, rising edge); reset in 1 (synchronous, active-high).
REQ-002 SHALL have inputs Op in 2, Funct in 6, Rd in 4, Cond in 4: instruction fields [27:26], [25:20], [15:12], [31:28].
REQ-003 SHALL have input ALUFlags in 4, the NZCV flags from the ALU in the current cycle.
REQ-004 SHALL have outputs PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA (out 1 each).
REQ-005 SHALL have outputs ResultSrc out 2, ALUSrcB out 2 and ALUControl out 4.
REQ-006 SHALL have input mem_ready in 1, present only when MC_CTRL_WAIT_EN is defined.

Function
REQ-007 SHALL sequence the shared datapath (one ALU, one memory) through the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB and BRANCH.
REQ-008 SHALL make these transitions:
- FETCH→DECODE.
- DECODE: Op=01→MEMADR; Op=00 with Funct[5]=0→EXECR; Op=00 with Funct[5]=1→EXECI; Op=10→BRANCH; Op=11→FETCH, with no writes.
- MEMADR: Funct[0]=1→MEMRD, else MEMWR.
- MEMRD→MEMWB→FETCH; MEMWR→FETCH.
- EXECR→ALUWB; EXECI→ALUWB; ALUWB→FETCH; BRANCH→FETCH.
REQ-009 In FETCH the block SHALL drive AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1 and PCWrite=1, with ALU=ADD.
REQ-010 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10, ResultSrc=10 and ALU=ADD, with no writes.
REQ-011 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=01 and ALU=ADD.
REQ-012 MEMRD SHALL drive AdrSrc=1; MEMWR SHALL drive AdrSrc=1 and MemWrite=CondEx.
REQ-013 MEMWB SHALL drive ResultSrc=01 and RegWrite=CondEx.
REQ-014 EXECR SHALL drive ALUSrcB=00 and EXECI SHALL drive ALUSrcB=01, both with ALUSrcA=0 and ALU decoded from Funct[4:1].
REQ-015 ALUWB SHALL drive ResultSrc=00 and RegWrite=CondEx&~NoWrite.
REQ-016 BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALU=ADD and PCWrite=CondEx.
REQ-017 In MEMWB and ALUWB with Rd=1111, the block SHALL also assert PCWrite=CondEx and SHALL deassert RegWrite.
REQ-018 ALU decode SHALL be Funct[4:1]: 0100→ADD, 0010→SUB, 0000→AND, 1100→ORR, 1010 (CMP)→SUB with NoWrite=1; all other values →ADD.
REQ-019 Any output not listed for a state SHALL be 0.
REQ-020 CondEx SHALL be evaluated combinationally from Cond and the stored flag register: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; Cond=1111 gives CondEx=0.
REQ-021 The 4-bit flag register SHALL update only at the EXECR/EXECI edge when Funct[0]=1 and CondEx=1:
- ADD/SUB/CMP load NZCV.
- AND/ORR load NZ only; C and V are held.
REQ-022 When an instruction has CondEx=0, its state path SHALL still be traversed, but no write strobe SHALL be asserted.
REQ-023 Controller latency in cycles SHALL be: branch 3, data-processing 4, STR 4, LDR 5.

Reset
REQ-024 With reset=1 at a rising edge, state SHALL become FETCH and flags SHALL become 0000.
REQ-025 While reset=1, PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced to 0; all other outputs take their FETCH values.
REQ-026 Reset asserted mid-instruction SHALL abandon that instruction without any write strobe on that cycle.

Configuration
REQ-027 Macro MC_CTRL_WAIT_EN SHALL control the mem_ready handshake.
- When defined: FETCH, MEMRD and MEMWR SHALL hold state, and suppress IRWrite/PCWrite/MemWrite, until mem_ready=1. The strobes SHALL fire in the cycle mem_ready=1 and the state SHALL advance at that edge.
- When undefined: mem_ready SHALL be absent and those states SHALL take one cycle.

Structure
REQ-028 Package mc_ctrl_pkg SHALL hold the state enum, the ALUControl encodings (ADD=0000, SUB=0001, AND=0010, ORR=0011) and the Cond encodings.
REQ-029 Condition evaluation and the flag register SHALL be in sub-module mc_cond_unit; the FSM and output decode SHALL be in multicycle_ctrl.

Verification
REQ-030 Reset held for 2 cycles, then released: state FETCH, all write strobes 0 during reset, IRWrite=1 on the first cycle after release.
REQ-031 ADD R0,R1,#42 (Op=00, Funct=101000, Rd=0000, Cond=1110): FETCH→DECODE→EXECI→ALUWB, with RegWrite=1 only in ALUWB and ALUControl=0000.
REQ-032 CMP (Funct=010101) with ALUFlags=0100: flags become 0100 and RegWrite stays 0 in ALUWB; a following BEQ (Op=10, Cond=0000) asserts PCWrite in BRANCH.
REQ-033 Cover two loads:
- LDR (Op=01, Funct=011001, Rd=0010) passes through MEMRD and MEMWB, with RegWrite=1 only in MEMWB.
- The same LDR with Rd=1111 asserts PCWrite instead of RegWrite.
REQ-034 STR (Op=01, Funct=011000) with Cond=0001 while Z=1 traverses MEMWR with MemWrite=0; Op=11 returns DECODE→FETCH with no strobes.
REQ-035 With MC_CTRL_WAIT_EN defined and mem_ready=0 for 3 cycles in FETCH: state holds and IRWrite=0, then IRWrite=1 in the cycle mem_ready=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller.
// Holds the FSM state enum, ALUControl and Cond encodings, the control-word
// payload struct and the ALU command decoder used by multicycle_ctrl.
package mc_ctrl_pkg;

   localparam int unsigned OP_W     = 2;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned RD_W     = 4;
   localparam int unsigned COND_W   = 4;
   localparam int unsigned FLAGS_W  = 4;
   localparam int unsigned ALUCTL_W = 4;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
      S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
   } state_t;

   typedef enum logic [ALUCTL_W-1:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_AND = 4'b0010,
      ALU_ORR = 4'b0011
   } alu_ctl_t;

   typedef enum logic [COND_W-1:0] {
      COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
      COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
      COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
      COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
   } cond_t;

   // One cycle's worth of datapath control
   typedef struct packed {
      logic       pcwrite;
      logic       adrsrc;
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] resultsrc;
      logic [1:0] alusrcb;
      alu_ctl_t   alucontrol;
   } ctrl_t;

   typedef struct packed {
      alu_ctl_t ctl;
      logic     nowrite;
   } alu_dec_t;

   // Funct[4:1] command decode; CMP is a SUB whose result is discarded
   function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
      alu_dec_t d;
      d.ctl     = ALU_ADD;
      d.nowrite = 1'b0;
      case (cmd)
         4'b0100: d.ctl = ALU_ADD;
         4'b0010: d.ctl = ALU_SUB;
         4'b0000: d.ctl = ALU_AND;
         4'b1100: d.ctl = ALU_ORR;
         4'b1010: begin
            d.ctl     = ALU_SUB;
            d.nowrite = 1'b1;
         end
         default: d.ctl = ALU_ADD;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mc_cond_unit.sv
// Condition evaluation and NZCV flag register.
// Ports: clk, reset (sync, active-high); cond - instruction condition field;
// aluflags - NZCV from the ALU this cycle; flag_we - load flags at this edge;
// nz_only - load N and Z only, hold C and V; condex_c - combinational
// condition result from the stored flags.
module mc_cond_unit
   import mc_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [COND_W-1:0]  cond,
   input  logic [FLAGS_W-1:0] aluflags,
   input  logic               flag_we,
   input  logic               nz_only,
   output logic               condex_c
);

   logic [FLAGS_W-1:0] flags;
   logic n, z, c, v;

   assign {n, z, c, v} = flags;

   // Flag register; logical ops leave carry and overflow untouched
   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= '0;
      end else if (flag_we) begin
         flags <= nz_only ? {aluflags[3:2], flags[1:0]} : aluflags;
      end
   end

   // Condition decode against the stored flags
   always_comb begin
      condex_c = 1'b0;
      case (cond_t'(cond))
         COND_EQ: condex_c = z;
         COND_NE: condex_c = ~z;
         COND_CS: condex_c = c;
         COND_CC: condex_c = ~c;
         COND_MI: condex_c = n;
         COND_PL: condex_c = ~n;
         COND_VS: condex_c = v;
         COND_VC: condex_c = ~v;
         COND_HI: condex_c = c & ~z;
         COND_LS: condex_c = ~c | z;
         COND_GE: condex_c = (n == v);
         COND_LT: condex_c = (n != v);
         COND_GT: condex_c = ~z & (n == v);
         COND_LE: condex_c = z | (n != v);
         COND_AL: condex_c = 1'b1;
         default: condex_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: sequences the shared ALU/memory datapath per instruction.
// Ports: clk, reset (sync, active-high); Op, Funct, Rd, Cond - instruction
// fields; ALUFlags - NZCV from the ALU; mem_ready - memory handshake (only with
// MC_CTRL_WAIT_EN defined); PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
// ALUSrcA, ResultSrc, ALUSrcB, ALUControl - datapath controls decoded from state.
// Build option: define MC_CTRL_WAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready.
module multicycle_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [OP_W-1:0]     Op,
   input  logic [FUNCT_W-1:0]  Funct,
   input  logic [RD_W-1:0]     Rd,
   input  logic [COND_W-1:0]   Cond,
   input  logic [FLAGS_W-1:0]  ALUFlags,
`ifdef MC_CTRL_WAIT_EN
   input  logic                mem_ready,
`endif
   output logic                PCWrite,
   output logic                AdrSrc,
   output logic                MemWrite,
   output logic                IRWrite,
   output logic                RegWrite,
   output logic                ALUSrcA,
   output logic [1:0]          ResultSrc,
   output logic [1:0]          ALUSrcB,
   output logic [ALUCTL_W-1:0] ALUControl
);

   state_t   state, state_next;
   ctrl_t    c;
   alu_dec_t dec;
   logic     condex;
   logic     flag_we;
   logic     nz_only;
   logic     rd_pc;
   logic     mem_ok;

`ifdef MC_CTRL_WAIT_EN
   assign mem_ok = mem_ready;
`else
   assign mem_ok = 1'b1;
`endif

   assign dec     = alu_decode(Funct[4:1]);
   assign nz_only = (dec.ctl == ALU_AND) || (dec.ctl == ALU_ORR);
   assign rd_pc   = (Rd == '1);

   mc_cond_unit u_cond (
      .clk      (clk),
      .reset    (reset),
      .cond     (Cond),
      .aluflags (ALUFlags),
      .flag_we  (flag_we),
      .nz_only  (nz_only),
      .condex_c (condex)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_next;
   end

   // Next state and per-state controls; strobes are qualified by CondEx
   always_comb begin
      state_next = state;
      c          = '0;
      flag_we    = 1'b0;
      case (state)
         S_FETCH: begin
            c.alusrca    = 1'b1;
            c.alusrcb    = 2'b10;
            c.resultsrc  = 2'b10;
            c.alucontrol = ALU_ADD;
            c.irwrite    = mem_ok;
            c.pcwrite    = mem_ok;
            if (mem_ok) state_next = S_DECODE;
         end
         S_DECODE: begin
            c.alusrca    = 1'b1;
            c.alusrcb    = 2'b10;
            c.resultsrc  = 2'b10;
            c.alucontrol = ALU_ADD;
            case (Op)
               2'b01:   state_next = S_MEMADR;
               2'b00:   state_next = Funct[5] ? S_EXECI : S_EXECR;
               2'b10:   state_next = S_BRANCH;
               default: state_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            c.alusrcb    = 2'b01;
            c.alucontrol = ALU_ADD;
            state_next   = Funct[0] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            c.adrsrc = 1'b1;
            if (mem_ok) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            c.resultsrc = 2'b01;
            if (rd_pc) c.pcwrite  = condex;
            else       c.regwrite = condex;
            state_next = S_FETCH;
         end
         S_MEMWR: begin
            c.adrsrc   = 1'b1;
            c.memwrite = condex & mem_ok;
            if (mem_ok) state_next = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            c.alusrcb    = (state == S_EXECI) ? 2'b01 : 2'b00;
            c.alucontrol = dec.ctl;
            flag_we      = Funct[0] & condex;
            state_next   = S_ALUWB;
         end
         S_ALUWB: begin
            c.resultsrc = 2'b00;
            if (rd_pc) c.pcwrite  = condex;
            else       c.regwrite = condex & ~dec.nowrite;
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            c.alusrcb    = 2'b01;
            c.resultsrc  = 2'b10;
            c.alucontrol = ALU_ADD;
            c.pcwrite    = condex;
            state_next   = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase

      // Reset presents FETCH steering with every write strobe and flag load held off
      if (reset) begin
         c            = '0;
         c.alusrca    = 1'b1;
         c.alusrcb    = 2'b10;
         c.resultsrc  = 2'b10;
         c.alucontrol = ALU_ADD;
         flag_we      = 1'b0;
      end
   end

   assign PCWrite    = c.pcwrite;
   assign AdrSrc     = c.adrsrc;
   assign MemWrite   = c.memwrite;
   assign IRWrite    = c.irwrite;
   assign RegWrite   = c.regwrite;
   assign ALUSrcA    = c.alusrca;
   assign ResultSrc  = c.resultsrc;
   assign ALUSrcB    = c.alusrcb;
   assign ALUControl = c.alucontrol;

endmodule
